// File: rtl/mcpu_pkg.sv
// Shared encodings for the MCPU multi-cycle control unit: states, opcode/funct
// values, ALU operation codes, datapath mux select codes and the control bundle.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_RX     = 4'd6,
        S_RWB    = 4'd7,
        S_IX     = 4'd8,
        S_IWB    = 4'd9,
        S_BR     = 4'd10,
        S_J      = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALU operations
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    // Datapath mux selects
    localparam logic       A_PC       = 1'b0;
    localparam logic       A_RS       = 1'b1;
    localparam logic [1:0] B_RT       = 2'b00;
    localparam logic [1:0] B_FOUR     = 2'b01;
    localparam logic [1:0] B_IMM      = 2'b10;
    localparam logic [1:0] B_IMM_SH2  = 2'b11;
    localparam logic [1:0] DST_RT     = 2'b00;
    localparam logic [1:0] DST_RD     = 2'b01;
    localparam logic [1:0] DST_RA     = 2'b10;
    localparam logic [1:0] M2R_ALU    = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    // Everything the FSM drives into the datapath, in one bundle
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       mem_we;
        logic       reg_we;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mcpu_control_alu_dec.sv
// ALU operation decode: R-type funct -> op (with illegal flag) and I-type
// opcode -> op. Purely combinational.
module mcpu_alu_dec
    import mcpu_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    output logic [2:0]     r_op,
    output logic           r_illegal,
    output logic [2:0]     i_op
);

    // funct/opcode to ALU operation lookup
    always_comb begin
        r_op      = ALU_ADD;
        r_illegal = 1'b0;
        case (funct)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_SLT:  r_op = ALU_SLT;
            default: r_illegal = 1'b1;
        endcase
        i_op = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
    end

endmodule

// File: rtl/mcpu_control.sv
// Multi-cycle control FSM for the MCPU datapath. Outputs are decoded from the
// state register (the branch PC write additionally looks at the live zero flag)
// and are all forced idle while reset is asserted.
module mcpu_control
    import mcpu_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int FNW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic [FNW-1:0]    funct,
    input  logic              zero,
    output logic              pc_we,
    output logic              ir_we,
    output logic              mem_we,
    output logic              reg_we,
    output logic              iord,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic [1:0]        pc_src,
    output logic [3:0]        state,
    output logic              instr_done,
    output logic              trap
);

    state_t     state_q, state_d;
    ctrl_t      ctrl;
    logic [2:0] r_op, i_op;
    logic       r_illegal;

    mcpu_alu_dec #(.OPW(OPW), .FNW(FNW)) u_alu_dec (
        .opcode    (opcode),
        .funct     (funct),
        .r_op      (r_op),
        .r_illegal (r_illegal),
        .i_op      (i_op)
    );

    // State register; reset always lands on FETCH
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        ctrl    = CTRL_IDLE;
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_we     = 1'b1;
                ctrl.pc_we     = 1'b1;
                ctrl.alu_src_b = B_FOUR;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= PC+4 + (imm<<2): branch target ready for BR
                ctrl.alu_src_b = B_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MADDR;
                    OP_RTYPE:         state_d = (funct == FN_JR) ? S_JR : S_RX;
                    OP_ADDI, OP_XORI: state_d = S_IX;
                    OP_BEQ, OP_BNE:   state_d = S_BR;
                    OP_J:             state_d = S_J;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_MADDR: begin
                ctrl.alu_src_a = A_RS;
                ctrl.alu_src_b = B_IMM;
                state_d        = (opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MWB;
            end
            S_MWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.instr_done = 1'b1;
            end
            S_MWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_RX: begin
                ctrl.alu_src_a = A_RS;
                ctrl.alu_src_b = B_RT;
                ctrl.alu_op    = r_op;
                state_d        = r_illegal ? S_TRAP : S_RWB;
            end
            S_RWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = DST_RD;
                ctrl.mem_to_reg = M2R_ALU;
                ctrl.instr_done = 1'b1;
            end
            S_IX: begin
                ctrl.alu_src_a = A_RS;
                ctrl.alu_src_b = B_IMM;
                ctrl.alu_op    = i_op;
                state_d        = S_IWB;
            end
            S_IWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = M2R_ALU;
                ctrl.instr_done = 1'b1;
            end
            S_BR: begin
                // rs - rt compared here; take the precomputed target on match
                ctrl.alu_src_a  = A_RS;
                ctrl.alu_src_b  = B_RT;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PCS_ALUOUT;
                ctrl.pc_we      = (opcode == OP_BNE) ? ~zero : zero;
                ctrl.instr_done = 1'b1;
            end
            S_J: begin
                ctrl.pc_we      = 1'b1;
                ctrl.pc_src     = PCS_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds the return address (PC+4 from FETCH)
                ctrl.pc_we      = 1'b1;
                ctrl.pc_src     = PCS_JUMP;
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = DST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.instr_done = 1'b1;
            end
            S_JR: begin
                ctrl.pc_we      = 1'b1;
                ctrl.pc_src     = PCS_RS;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.trap = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                // unused encoding: idle outputs, recover via FETCH
                state_d = S_FETCH;
            end
        endcase
        if (reset) ctrl = CTRL_IDLE;
    end

    assign pc_we      = ctrl.pc_we;
    assign ir_we      = ctrl.ir_we;
    assign mem_we     = ctrl.mem_we;
    assign reg_we     = ctrl.reg_we;
    assign iord       = ctrl.iord;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign pc_src     = ctrl.pc_src;
    assign instr_done = ctrl.instr_done;
    assign trap       = ctrl.trap;
    assign state      = state_q;

endmodule

// File: tb/tb_mcpu_control.sv
// Directed bench for mcpu_control: walks each instruction class state by state
// and compares state plus the full control vector against hand-written values.
module tb_mcpu_control;
    import mcpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pc_we, ir_we, mem_we, reg_we, iord, alu_src_a;
    logic [1:0] alu_src_b, reg_dst, mem_to_reg, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       instr_done, trap;

    int errors = 0;
    int checks = 0;

    mcpu_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .iord       (iord),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .state      (state),
        .instr_done (instr_done),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    // Field order: pc_we ir_we mem_we reg_we | iord a | b[2] | op[3] | dst[2] m2r[2] src[2] | done trap
    logic [18:0] obs;
    assign obs = {pc_we, ir_we, mem_we, reg_we, iord, alu_src_a, alu_src_b, alu_op,
                  reg_dst, mem_to_reg, pc_src, instr_done, trap};

    localparam logic [18:0] E_IDLE   = {4'b0000, 2'b00, 2'b00, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_FETCH  = {4'b1100, 2'b00, 2'b01, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_DECODE = {4'b0000, 2'b00, 2'b11, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_MADDR  = {4'b0000, 2'b01, 2'b10, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_MRD    = {4'b0000, 2'b10, 2'b00, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_MWB    = {4'b0001, 2'b00, 2'b00, 3'd0, 2'b00, 2'b01, 2'b00, 2'b10};
    localparam logic [18:0] E_MWR    = {4'b0010, 2'b10, 2'b00, 3'd0, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [18:0] E_RX_ADD = {4'b0000, 2'b01, 2'b00, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_RX_SUB = {4'b0000, 2'b01, 2'b00, 3'd1, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_RX_SLT = {4'b0000, 2'b01, 2'b00, 3'd3, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_RWB    = {4'b0001, 2'b00, 2'b00, 3'd0, 2'b01, 2'b00, 2'b00, 2'b10};
    localparam logic [18:0] E_IX_ADD = {4'b0000, 2'b01, 2'b10, 3'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_IX_XOR = {4'b0000, 2'b01, 2'b10, 3'd2, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] E_IWB    = {4'b0001, 2'b00, 2'b00, 3'd0, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [18:0] E_BR_TK  = {4'b1000, 2'b01, 2'b00, 3'd1, 2'b00, 2'b00, 2'b01, 2'b10};
    localparam logic [18:0] E_BR_NT  = {4'b0000, 2'b01, 2'b00, 3'd1, 2'b00, 2'b00, 2'b01, 2'b10};
    localparam logic [18:0] E_J      = {4'b1000, 2'b00, 2'b00, 3'd0, 2'b00, 2'b00, 2'b10, 2'b10};
    localparam logic [18:0] E_JAL    = {4'b1001, 2'b00, 2'b00, 3'd0, 2'b10, 2'b10, 2'b10, 2'b10};
    localparam logic [18:0] E_JR     = {4'b1000, 2'b00, 2'b00, 3'd0, 2'b00, 2'b00, 2'b11, 2'b10};
    localparam logic [18:0] E_TRAP   = {4'b0000, 2'b00, 2'b00, 3'd0, 2'b00, 2'b00, 2'b00, 2'b01};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [18:0] exp_sig);
        checks++;
        assert (state === exp_st) else begin
            errors++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state, exp_st);
        end
        checks++;
        assert (obs === exp_sig) else begin
            errors++;
            $error("FAIL %s ctrl got=%05h exp=%05h", tag, obs, exp_sig);
        end
    endtask

    // Present an instruction in FETCH, check FETCH and DECODE, leave DUT in the
    // state after DECODE.
    task automatic run_fd(input string tag, input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        #1;
        chk({tag, "/fetch"}, S_FETCH, E_FETCH);
        tick();
        chk({tag, "/decode"}, S_DECODE, E_DECODE);
        tick();
    endtask

    initial begin
        // reset held two cycles
        tick();
        chk("rst_c0", S_FETCH, E_IDLE);
        tick();
        chk("rst_c1", S_FETCH, E_IDLE);
        reset = 1'b0;

        // lw: 5 cycles
        run_fd("lw", OP_LW, 6'h00);
        chk("lw/maddr", S_MADDR, E_MADDR);
        tick(); chk("lw/mrd", S_MRD, E_MRD);
        tick(); chk("lw/mwb", S_MWB, E_MWB);
        tick();

        // sw: 4 cycles
        run_fd("sw", OP_SW, 6'h00);
        chk("sw/maddr", S_MADDR, E_MADDR);
        tick(); chk("sw/mwr", S_MWR, E_MWR);
        tick();

        // R-type sub, slt, add
        run_fd("sub", OP_RTYPE, FN_SUB);
        chk("sub/rx", S_RX, E_RX_SUB);
        tick(); chk("sub/rwb", S_RWB, E_RWB);
        tick();
        run_fd("slt", OP_RTYPE, FN_SLT);
        chk("slt/rx", S_RX, E_RX_SLT);
        tick(); chk("slt/rwb", S_RWB, E_RWB);
        tick();
        run_fd("add", OP_RTYPE, FN_ADD);
        chk("add/rx", S_RX, E_RX_ADD);
        tick(); chk("add/rwb", S_RWB, E_RWB);
        tick();

        // I-type addi, xori
        run_fd("addi", OP_ADDI, 6'h15);
        chk("addi/ix", S_IX, E_IX_ADD);
        tick(); chk("addi/iwb", S_IWB, E_IWB);
        tick();
        run_fd("xori", OP_XORI, 6'h20);
        chk("xori/ix", S_IX, E_IX_XOR);
        tick(); chk("xori/iwb", S_IWB, E_IWB);
        tick();

        // jr: 3 cycles
        run_fd("jr", OP_RTYPE, FN_JR);
        chk("jr/jr", S_JR, E_JR);
        tick();

        // branches, both polarities of zero
        zero = 1'b1;
        run_fd("beq_z1", OP_BEQ, 6'h00);
        chk("beq_z1/br", S_BR, E_BR_TK);
        tick();
        zero = 1'b0;
        run_fd("beq_z0", OP_BEQ, 6'h00);
        chk("beq_z0/br", S_BR, E_BR_NT);
        tick();
        run_fd("bne_z0", OP_BNE, 6'h00);
        chk("bne_z0/br", S_BR, E_BR_TK);
        tick();
        zero = 1'b1;
        run_fd("bne_z1", OP_BNE, 6'h00);
        chk("bne_z1/br", S_BR, E_BR_NT);
        tick();
        zero = 1'b0;

        // j, jal
        run_fd("j", OP_J, 6'h00);
        chk("j/j", S_J, E_J);
        tick();
        run_fd("jal", OP_JAL, 6'h00);
        chk("jal/jal", S_JAL, E_JAL);
        tick();

        // reset asserted in MRD aborts the load
        run_fd("lwrst", OP_LW, 6'h00);
        chk("lwrst/maddr", S_MADDR, E_MADDR);
        tick(); chk("lwrst/mrd", S_MRD, E_MRD);
        reset = 1'b1;
        #1;
        chk("lwrst/rst_mrd", S_MRD, E_IDLE);
        tick(); chk("lwrst/rst_c0", S_FETCH, E_IDLE);
        tick(); chk("lwrst/rst_c1", S_FETCH, E_IDLE);
        reset = 1'b0;

        // illegal funct traps out of RX
        run_fd("badfn", OP_RTYPE, 6'h3F);
        chk("badfn/rx", S_RX, E_RX_ADD);
        tick(); chk("badfn/trap0", S_TRAP, E_TRAP);
        tick(); chk("badfn/trap1", S_TRAP, E_TRAP);
        reset = 1'b1;
        tick(); chk("badfn/rst", S_FETCH, E_IDLE);
        reset = 1'b0;

        // illegal opcode: trap held for 10 cycles until reset
        run_fd("badop", 6'h3F, 6'h00);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("badop/trap%0d", i), S_TRAP, E_TRAP);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("badop/rst_in", S_TRAP, E_IDLE);
        tick(); chk("badop/rst", S_FETCH, E_IDLE);
        reset = 1'b0;
        #1;
        chk("badop/fetch", S_FETCH, E_FETCH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
